// File: rtl/handshake_req.sv
// -----------------------------------------------------------------------------
// handshake_req
//
// Initiator side of the four-phase R/A request-accept handshake. A GO command
// starts a burst of LEN transfers. Each transfer offers a word on DOUT, raises
// R, waits for A to rise, drops R, then waits for A to fall. Completion is
// reported with a one-cycle DONE pulse. An acceptor that stalls for TMO cycles
// on either edge aborts the burst and sets the sticky ERR flag.
//
// Parameters:
//   DW  - data width
//   LW  - width of LEN and CNT
//   TMO - cycles spent waiting for an A edge before aborting (1..255)
//
// Ports:
//   CLK  in  1   rising-edge clock
//   RST  in  1   asynchronous active-low reset
//   GO   in  1   start-burst command, sampled in IDLE
//   LEN  in  LW  transfers in the burst, sampled with GO (0 = ignore GO)
//   DIN  in  DW  next data word, sampled on each entry to REQ
//   A    in  1   accept from the acceptor (same clock domain)
//   R    out 1   request to the acceptor
//   DOUT out DW  word on offer, stable while R = 1
//   CNT  out LW  transfers remaining, including the one in progress
//   BUSY out 1   high in every state except IDLE
//   DONE out 1   one-cycle pulse after the last transfer completes
//   ERR  out 1   sticky timeout flag, cleared by the next accepted GO
// -----------------------------------------------------------------------------
module handshake_req #(
  parameter int DW  = 8,
  parameter int LW  = 4,
  parameter int TMO = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          GO,
  input  logic [LW-1:0] LEN,
  input  logic [DW-1:0] DIN,
  input  logic          A,
  output logic          R,
  output logic [DW-1:0] DOUT,
  output logic [LW-1:0] CNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2,
    S_ERRW = 2'd3
  } state_t;

  // The wait counter is compared against TMO-1 because the abort happens on
  // the edge at which the count would reach TMO, i.e. after TMO cycles in
  // which the awaited A level never appeared.
  localparam logic [7:0] WAIT_LAST = 8'(TMO - 1);

  state_t        r_state;
  logic [7:0]    r_wait;
  logic          r_req;
  logic [DW-1:0] r_dout;
  logic [LW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_timeout;
  logic w_start;

  assign w_timeout = (r_wait == WAIT_LAST);
  // A new request may only be raised once the acceptor has released A.
  assign w_start   = GO && (LEN != '0) && !A;

  // Single state machine; every output is a register so R cannot glitch
  // into the acceptor.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of statement
  // order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // Asynchronous clear: R drops the moment reset asserts, even mid-burst.
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_req   <= 1'b0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // DONE is a pulse: it is only ever set for the single REL->IDLE edge.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // GO is also honoured while DONE is high, giving back-to-back bursts.
          if (w_start) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_dout  <= DIN;
            r_cnt   <= LEN;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_wait  <= '0;
          end
        end

        S_REQ: begin
          if (A) begin
            r_state <= S_REL;
            r_req   <= 1'b0;
            r_cnt   <= r_cnt - 1'b1;
            r_wait  <= '0;
          end else if (w_timeout) begin
            // CNT is left alone so it still counts the failed transfer.
            r_state <= S_ERRW;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        S_REL: begin
          if (!A) begin
            r_wait <= '0;
            if (r_cnt != '0) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_dout  <= DIN;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_ERRW;
            r_err   <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        S_ERRW: begin
          // Return to IDLE only once the acceptor has let go of A, so the
          // next burst starts from a clean protocol state. No DONE here.
          if (!A) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign R    = r_req;
  assign DOUT = r_dout;
  assign CNT  = r_cnt;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule

// File: tb/tb_handshake_req.sv
// -----------------------------------------------------------------------------
// tb_handshake_req
//
// Directed bench for handshake_req with default parameters (DW=8, LW=4,
// TMO=15). Inputs change 1 ns after each rising edge; outputs are checked at
// the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_handshake_req;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          GO;
  logic [LW-1:0] LEN;
  logic [DW-1:0] DIN;
  logic          A;
  logic          R;
  logic [DW-1:0] DOUT;
  logic [LW-1:0] CNT;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  int n_cmp = 0;
  int n_err = 0;

  handshake_req #(.DW(DW), .LW(LW), .TMO(15)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .GO   (GO),
    .LEN  (LEN),
    .DIN  (DIN),
    .A    (A),
    .R    (R),
    .DOUT (DOUT),
    .CNT  (CNT),
    .BUSY (BUSY),
    .DONE (DONE),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin : stim
    logic [DW-1:0] burst_data [3];
    burst_data[0] = 8'h11;
    burst_data[1] = 8'h22;
    burst_data[2] = 8'h33;

    // ---------------- reset ----------------
    RST = 1'b0; GO = 1'b0; LEN = '0; DIN = '0; A = 1'b0;
    tick(); tick();
    check("rst_R",    R,    0);
    check("rst_DOUT", DOUT, 0);
    check("rst_CNT",  CNT,  0);
    check("rst_BUSY", BUSY, 0);
    check("rst_DONE", DONE, 0);
    check("rst_ERR",  ERR,  0);
    RST = 1'b1;
    tick();

    // ---------------- basic burst, acceptor echoes R one cycle late ----------
    GO = 1'b1; LEN = 4'd3; DIN = burst_data[0];
    tick();
    GO = 1'b0;
    check("b_CNT0", CNT, 3);
    for (int i = 0; i < 3; i++) begin
      DIN = (i < 2) ? burst_data[i+1] : 8'hEE;
      check("b_R_up",  R,    1);
      check("b_DOUT",  DOUT, burst_data[i]);
      check("b_BUSY",  BUSY, 1);
      tick();                          // A still 0 this cycle
      check("b_R_hold", R, 1);
      A = 1'b1;
      tick();                          // A=1 sampled -> REL
      check("b_R_down", R,   0);
      check("b_CNT",    CNT, 2 - i);
      tick();                          // A still 1 (echo of R one cycle late)
      check("b_R_low",  R, 0);
      A = 1'b0;
      tick();                          // A=0 sampled -> REQ or IDLE
    end
    check("b_DONE",   DONE, 1);
    check("b_BUSYlo", BUSY, 0);
    check("b_R_idle", R,    0);
    check("b_DOUT_hold", DOUT, 8'h33);
    tick();
    check("b_DONE_pulse", DONE, 0);

    // ---------------- slow acceptor ----------------
    GO = 1'b1; LEN = 4'd1; DIN = 8'h5A;
    tick();
    GO = 1'b0; DIN = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s_R_hold",    R,    1);
      check("s_DOUT_hold", DOUT, 8'h5A);
      check("s_ERR",       ERR,  0);
    end
    A = 1'b1;
    tick();
    check("s_R_down", R,   0);
    check("s_CNT",    CNT, 0);
    A = 1'b0;
    tick();
    check("s_DONE", DONE, 1);
    check("s_ERR2", ERR,  0);
    tick();

    // ---------------- timeout: A tied 0 ----------------
    GO = 1'b1; LEN = 4'd2; DIN = 8'hC3;
    tick();                            // edge n: R rises
    GO = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    check("t_R_14", R, 1);
    tick();                            // edge n+15: timeout
    check("t_R_fall", R,    0);
    check("t_ERR",    ERR,  1);
    check("t_CNT",    CNT,  2);
    check("t_BUSY",   BUSY, 1);
    check("t_DONE",   DONE, 0);
    tick();                            // ERRW -> IDLE (A=0)
    check("t_idle_BUSY", BUSY, 0);
    check("t_idle_DONE", DONE, 0);
    check("t_ERR_sticky", ERR, 1);

    // ---------------- illegal starts ----------------
    GO = 1'b1; LEN = 4'd0;
    tick();
    check("i_len0_R",    R,    0);
    check("i_len0_BUSY", BUSY, 0);
    check("i_len0_ERR",  ERR,  1);
    LEN = 4'd1; A = 1'b1;
    tick();
    check("i_A1_R",    R,    0);
    check("i_A1_BUSY", BUSY, 0);
    // Accepted GO clears ERR.
    A = 1'b0; LEN = 4'd2; DIN = 8'h77;
    tick();
    check("i_go_R",   R,    1);
    check("i_go_ERR", ERR,  0);
    check("i_go_CNT", CNT,  2);
    check("i_go_DOUT", DOUT, 8'h77);
    LEN = 4'd5; DIN = 8'h88;           // GO still high during the burst
    tick();
    check("i_busy_CNT", CNT, 2);
    check("i_busy_R",   R,   1);
    GO = 1'b0; A = 1'b1;
    tick();
    check("i_x1_CNT", CNT, 1);
    A = 1'b0;
    tick();
    check("i_x2_R",    R,    1);
    check("i_x2_DOUT", DOUT, 8'h88);
    A = 1'b1;
    tick();
    check("i_x2_CNT", CNT, 0);
    A = 1'b0;
    tick();
    check("i_DONE", DONE, 1);
    tick();

    // ---------------- reset mid-operation ----------------
    GO = 1'b1; LEN = 4'd3; DIN = 8'h99;
    tick();
    GO = 1'b0;
    check("r_R_up", R, 1);
    #2 RST = 1'b0;                     // between clock edges
    #1;
    check("r_async_R",    R,    0);
    check("r_async_BUSY", BUSY, 0);
    check("r_async_CNT",  CNT,  0);
    tick();
    RST = 1'b1;
    tick();
    GO = 1'b1; LEN = 4'd1; DIN = 8'h3C;
    tick();
    GO = 1'b0;
    check("r_go_R",    R,    1);
    check("r_go_DOUT", DOUT, 8'h3C);
    A = 1'b1;
    tick();
    check("r_R_down", R, 0);
    A = 1'b0;
    tick();
    check("r_DONE", DONE, 1);
    tick();

    // ---------------- back-to-back bursts ----------------
    GO = 1'b1; LEN = 4'd1; DIN = 8'h01;
    tick();
    check("bb_R1", R, 1);
    DIN = 8'h02; A = 1'b1;
    tick();
    A = 1'b0;
    tick();
    check("bb_DONE1", DONE, 1);
    check("bb_BUSY1", BUSY, 0);
    tick();                            // GO sampled while DONE=1
    GO = 1'b0;
    check("bb_R2",    R,    1);
    check("bb_DOUT2", DOUT, 8'h02);
    check("bb_DONE_lo", DONE, 0);
    check("bb_BUSY2", BUSY, 1);
    A = 1'b1;
    tick();
    A = 1'b0;
    tick();
    check("bb_DONE2", DONE, 1);
    tick();
    check("bb_DONE2_lo", DONE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_req.md
# handshake_req

- Four-phase requester: the initiator side of the R/A request–accept handshake used by the Rec&Accept logic.
- On a `GO` command it runs a burst of `LEN` transfers. For each transfer it presents a data word on `DOUT`, raises `R`, waits for `A`, drops `R`, then waits for `A` to fall.
- It reports completion with `DONE` and a stalled acceptor with `ERR` (timeout).
- It sits on the requesting side of the link; its `R` drives the acceptor's R input and it consumes the acceptor's `A`, all in the same clock domain.

## Interface

Parameters:
- `DW`, 8, data width.
- `LW`, 4, width of `LEN` and `CNT`.
- `TMO`, 15, maximum cycles spent waiting for an `A` edge before error; range 1..255.

Ports (clock and reset first):
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: reset, asynchronous and active-low.
- `GO` in 1: start-burst command, sampled in IDLE.
- `LEN` in LW: number of transfers in the burst, sampled with `GO`.
- `DIN` in DW: next data word, sampled on each entry to REQ.
- `A` in 1: accept/acknowledge from the acceptor.
- `R` out 1: request to the acceptor, registered.
- `DOUT` out DW: word being offered; stable while `R`=1.
- `CNT` out LW: transfers remaining, including the one in progress.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse after the last transfer completes.
- `ERR` out 1: sticky timeout flag.

## Operation

- States: IDLE, REQ, REL, ERRW. All outputs are registered.
- Reset (`RST`=0, asynchronous):
  - State goes to IDLE.
  - `R`=0, `DOUT`=0, `CNT`=0, `BUSY`=0, `DONE`=0, `ERR`=0.
  - Timeout counter is cleared.
  - Reset asserted mid-burst drops `R` immediately, without waiting for a clock edge.
- IDLE:
  - `GO`=1, `LEN`≠0 and `A`=0 → go to REQ with `R`=1, `DOUT`=`DIN`, `CNT`=`LEN`, `ERR`=0.
  - `GO` with `LEN`=0 is ignored.
  - `GO` with `A`=1 is ignored; the protocol forbids raising `R` while `A` is still high.
- REQ (`R`=1):
  - `A` sampled 1 → go to REL with `R`=0 and `CNT`=`CNT`−1.
- REL (`R`=0):
  - `A` sampled 0 and `CNT`≠0 → go to REQ with `R`=1 and `DOUT`=`DIN`.
  - `A` sampled 0 and `CNT`=0 → go to IDLE with `DONE`=1 for exactly one cycle and `BUSY`=0.
- Timeout:
  - An 8-bit wait counter clears on every entry to REQ or REL and increments each cycle the awaited `A` level is absent.
  - When it reaches `TMO` → go to ERRW with `R`=0 and `ERR`=1.
  - `CNT` holds the remaining count, including the failed transfer, for diagnosis.
- ERRW:
  - Go to IDLE once `A` is sampled 0.
  - `ERR` stays 1 until the next accepted `GO`.
  - No `DONE` pulse is issued.
- `GO` while `BUSY`=1 is ignored and has no effect.
- `DOUT` changes only on entry to REQ (or reset). It holds its last value in IDLE.

## Timing

- Burst start: `GO` sampled at edge n → `R`=1, `BUSY`=1 and `DOUT` valid after edge n.
- Handshake latency: `A` rising sampled at edge m → `R`=0 after edge m. `A` falling sampled at edge k → `R`=1 again after edge k if transfers remain.
- Minimum cost per transfer is 2 cycles (acceptor answering in zero cycles). Burst of N transfers with an immediate acceptor: `DONE` high in cycle 2N+1 after the `GO` edge.
- `DONE` and the next accepted `GO`:
  - `DONE` coincides with IDLE.
  - A `GO` sampled while `DONE`=1 is accepted, giving back-to-back bursts.
- Timeout fires at the edge on which the wait counter equals `TMO`, i.e. after `TMO` cycles with no `A` edge.
- `A` is assumed synchronous to `CLK`; no synchronizer is included.

## Test plan

- Basic burst: `LEN`=3, `DIN`=0x11/0x22/0x33; acceptor echoes `R` on `A` one cycle late → three `R` pulses with `DOUT` 0x11, 0x22, 0x33; `CNT` steps 3→2→1→0; one `DONE` pulse; `BUSY` drops with `DONE`.
- Slow acceptor: `A` raised 5 cycles after `R` → `R` holds 1 and `DOUT` holds stable for all 5 cycles; `ERR`=0.
- Timeout: `LEN`=2, `A` tied 0 → `R` falls after 15 cycles in REQ; `ERR`=1; `CNT`=2; no `DONE`; IDLE follows. The next `GO` clears `ERR`.
- Illegal starts:
  - `GO` with `LEN`=0 → no `R` and `BUSY` stays 0.
  - `GO` while `A`=1 → ignored.
  - `GO` during a burst → ignored, and `CNT` is unaffected.
- Reset mid-operation: assert `RST`=0 while `R`=1 between clock edges → `R`, `BUSY` and `CNT` go to 0 immediately. After release, a new `GO` with `LEN`=1 completes normally.
- Back-to-back: `GO` held high with `LEN`=1 → a second burst starts on the cycle `DONE` is high; `R` rises the following cycle.
